sram_axi_memtest: RTL
=====================

// Module: sram_axi_memtest
// PURPOSE
//  AXI4-Lite initiator that drives the sram_axi responder: on start, writes a pattern over
//  an address window, then reads the window back and checks every word. It is the
//  requester side of the aw/w/b/ar/r channels, used as a board self-test and bench stimulus.
//  One transaction is outstanding at a time. A pass/fail result and the first failing address are reported.
// PARAMETERS
//  ADDR_W   18        address width, word-addressed (matches sram_addr)
//  DATA_W   16        data width; w_strb is DATA_W/8 bits
//  SEED     16'hA5C3  pattern key: expected data = addr[DATA_W-1:0] ^ SEED
// PORTS
//  a_clk        in   1       clock
//  a_rst        in   1       synchronous reset, active-high
//  start        in   1       1-cycle pulse; ignored unless in IDLE or DONE
//  base_addr    in   ADDR_W  first address, sampled on start
//  last_addr    in   ADDR_W  last address (inclusive), sampled on start
//  busy         out  1       high from the cycle after start until DONE
//  done         out  1       high in DONE, held until the next start or reset
//  pass         out  1       valid when done: no errors seen
//  err_count    out  16      errors seen, saturates at 16'hFFFF
//  err_addr     out  ADDR_W  address of the first error
//  aw_valid/aw_ready out/in 1; aw_addr out ADDR_W; aw_prot out 1 (const 0)
//  w_valid/w_ready   out/in 1; w_data out DATA_W; w_strb out 2 (const 2'b11)
//  b_valid in 1; b_ready out 1; b_resp in 1 (1 = error)
//  ar_valid/ar_ready out/in 1; ar_addr out ADDR_W; ar_prot out 1 (const 0)
//  r_valid in 1; r_ready out 1; r_data in DATA_W; r_resp in 1 (1 = error)
// BEHAVIOUR
//  Reset: state IDLE; all valid/ready outputs 0; addr/data outputs 0; busy=0, done=0,
//   pass=0, err_count=0, err_addr=0. Reset mid-transaction aborts at once; no completion wait.
//  FSM: IDLE -start-> WR_REQ -> WR_RESP -> (next addr) WR_REQ | RD_REQ -> RD_RESP ->
//   (next addr) RD_REQ | DONE; DONE -start-> WR_REQ (clears err_count, err_addr, pass, done).
//  start in IDLE/DONE: latch base/last into cur=base, end=last; busy=1 on the next cycle.
//  WR_REQ: aw_valid=w_valid=1, aw_addr=cur, w_data=cur[DATA_W-1:0]^SEED. Each channel
//   drops its valid on the edge where valid&&ready; it goes to WR_RESP when both handshakes
//   are done (same or different cycles). Payload is stable while valid is high.
//  WR_RESP: b_ready=1. On b_valid: if b_resp, count an error. Then cur==end -> cur=base,
//   RD_REQ; else cur=cur+1 -> WR_REQ. Next aw_valid rises at the earliest 1 cycle after b.
//  RD_REQ: ar_valid=1, ar_addr=cur; on ar_ready -> RD_RESP, ar_valid=0.
//  RD_RESP: r_ready=1. On r_valid: error if r_resp || r_data != cur[DATA_W-1:0]^SEED.
//   cur==end -> DONE; else cur+1 -> RD_REQ.
//  Errors: err_count += 1 (saturating); err_addr is loaded only on the first error.
//  DONE: busy=0, done=1, pass=(err_count==0).
//  Address arithmetic is mod 2^ADDR_W. base>last runs through wrap-around (last-base+1 mod
//   2^ADDR_W words). base==last runs exactly one write and one read.
//  b_valid/r_valid outside WR_RESP/RD_RESP are ignored (ready=0). start while busy is ignored.
//  Latency per word with a zero-wait responder: write 2 cycles min, read 2 cycles min.
// TESTING
//  1. base=0,last=3, zero-wait echo responder storing writes -> 4 aw/w with data A5C3,A5C2,
//     A5C1,A5C0; 4 reads; done=1, pass=1, err_count=0.
//  2. Responder returns r_data=addr (no store), base=8,last=8 -> err_count=1, err_addr=8,
//     pass=0.
//  3. w_ready delayed 3 cycles after aw_ready -> aw_valid drops after 1 beat, w_valid stays
//     high and w_data stable; exactly one b per address.
//  4. b_resp=1 on addr 2 of 0..3 -> err_count=1, err_addr=2; read phase still runs.
//  5. base=3FFFE,last=1 -> addresses 3FFFE,3FFFF,0,1 in order; 4 writes and 4 reads.
//  6. a_rst at 1 cycle mid-WR_REQ -> next edge: all valids 0, busy=0; a new start runs clean.

Source files
------------

// File: rtl/sram_axi_memtest.sv
// AXI4-Lite memory self-test initiator: writes addr^SEED over [base..last], reads it back,
// and reports pass/fail with an error count and the first failing address.
module sram_axi_memtest #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned DATA_W = 16,
  parameter logic [DATA_W-1:0] SEED = DATA_W'(16'hA5C3)
) (
  input  logic                  a_clk,
  input  logic                  a_rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W-1:0]     last_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_count,
  output logic [ADDR_W-1:0]     err_addr,
  output logic                  aw_valid,
  input  logic                  aw_ready,
  output logic [ADDR_W-1:0]     aw_addr,
  output logic                  aw_prot,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [DATA_W-1:0]     w_data,
  output logic [DATA_W/8-1:0]   w_strb,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_resp,
  output logic                  ar_valid,
  input  logic                  ar_ready,
  output logic [ADDR_W-1:0]     ar_addr,
  output logic                  ar_prot,
  input  logic                  r_valid,
  output logic                  r_ready,
  input  logic [DATA_W-1:0]     r_data,
  input  logic                  r_resp
);

  typedef enum logic [2:0] {StIdle, StWrReq, StWrResp, StRdReq, StRdResp, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cur_q, cur_d, base_q, base_d, end_q, end_d;
  logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [15:0]         err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
  logic                err_hit, aw_fin, w_fin;

  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      state_q    <= StIdle;
      cur_q      <= '0;
      base_q     <= '0;
      end_q      <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      base_q     <= base_d;
      end_q      <= end_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    base_d     = base_q;
    end_d      = end_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    err_hit    = 1'b0;
    aw_fin     = 1'b0;
    w_fin      = 1'b0;
    aw_valid   = 1'b0;
    aw_addr    = '0;
    w_valid    = 1'b0;
    w_data     = '0;
    b_ready    = 1'b0;
    ar_valid   = 1'b0;
    ar_addr    = '0;
    r_ready    = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          cur_d      = base_addr;
          base_d     = base_addr;
          end_d      = last_addr;
          err_cnt_d  = '0;
          err_addr_d = '0;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          state_d    = StWrReq;
        end
      end
      StWrReq: begin
        // Each channel's valid falls independently once its own handshake completes.
        aw_valid = !aw_done_q;
        w_valid  = !w_done_q;
        aw_addr  = cur_q;
        w_data   = cur_q[DATA_W-1:0] ^ SEED;
        aw_fin   = aw_done_q || aw_ready;
        w_fin    = w_done_q || w_ready;
        if (aw_fin && w_fin) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = StWrResp;
        end else begin
          aw_done_d = aw_fin;
          w_done_d  = w_fin;
        end
      end
      StWrResp: begin
        b_ready = 1'b1;
        if (b_valid) begin
          err_hit = b_resp;
          if (cur_q == end_q) begin
            cur_d   = base_q;
            state_d = StRdReq;
          end else begin
            cur_d   = cur_q + ADDR_W'(1);
            state_d = StWrReq;
          end
        end
      end
      StRdReq: begin
        ar_valid = 1'b1;
        ar_addr  = cur_q;
        if (ar_ready) state_d = StRdResp;
      end
      StRdResp: begin
        r_ready = 1'b1;
        if (r_valid) begin
          err_hit = r_resp || (r_data != (cur_q[DATA_W-1:0] ^ SEED));
          if (cur_q == end_q) begin
            state_d = StDone;
          end else begin
            cur_d   = cur_q + ADDR_W'(1);
            state_d = StRdReq;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (err_hit) begin
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      if (err_cnt_q == 16'd0) err_addr_d = cur_q;
    end
  end

  assign busy      = (state_q != StIdle) && (state_q != StDone);
  assign done      = (state_q == StDone);
  assign pass      = done && (err_cnt_q == 16'd0);
  assign err_count = err_cnt_q;
  assign err_addr  = err_addr_q;
  assign aw_prot   = 1'b0;
  assign ar_prot   = 1'b0;
  assign w_strb    = '1;

endmodule
